result_uart_tx: RTL and testbench

Transmit side for the compute core's result interface. When the core signals completion on `end_process`, the block captures the four result words `r1`..`r4`. It then sends them off-chip as one framed, checksummed burst over a UART 8N1 line. It sits between `top`'s result outputs and the board's TX pin; the host-side reader is the other end of this protocol.

---
 rtl/result_uart_tx_if.sv | 13 +
 rtl/result_uart_tx.sv | 96 +++++++++
 tb/tb_result_uart_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/result_uart_tx_if.sv
// result_uart_tx_if: result words and completion flag from the core, UART line and status back.
interface result_uart_tx_if #(parameter int DATA_W = 8) ();
  logic              end_process;
  logic [DATA_W-1:0] r1;
  logic [DATA_W-1:0] r2;
  logic [DATA_W-1:0] r3;
  logic [DATA_W-1:0] r4;
  logic              tx;
  logic              busy;
  logic              done;
  modport master (output end_process, r1, r2, r3, r4, input tx, busy, done);
  modport slave (input end_process, r1, r2, r3, r4, output tx, busy, done);
endinterface

// File: rtl/result_uart_tx.sv
// result_uart_tx: captures r1..r4 on an end_process rising edge and sends sync, data bytes and XOR checksum as 8N1.
module result_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           rst_n,
  result_uart_tx_if.slave bus
);
  localparam int B   = DATA_W / 8;
  localparam int N   = 4 * B + 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BIW = $clog2(N);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  state_t              state;
  logic                ep_q;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [BIW-1:0]      byte_idx;
  logic [7:0]          sh;
  logic [7:0]          csum;
  logic [4*DATA_W-1:0] words_q;
  logic                tx_q;
  logic                busy_q;
  logic                done_q;
  logic                bit_end;
  assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ep_q     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      csum     <= '0;
      words_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ep_q <= bus.end_process;
      case (state)
        IDLE: if (bus.end_process && !ep_q) begin
          state   <= START;
          words_q <= {bus.r4, bus.r3, bus.r2, bus.r1};
          sh      <= 8'hA5;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
        end
        START: if (bit_end) begin
          cnt   <= '0;
          state <= DATA;
          tx_q  <= sh[0];
        end else cnt <= cnt + CW'(1);
        DATA: if (bit_end) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 3'd1;
          sh      <= sh >> 1;
          state   <= (bit_idx == 3'd7) ? STOP : DATA;
          tx_q    <= (bit_idx == 3'd7) ? 1'b1 : sh[1];
        end else cnt <= cnt + CW'(1);
        // The byte after the last data byte is the checksum; data bytes fold into it as they load.
        STOP: if (bit_end) begin
          cnt <= '0;
          if (byte_idx == BIW'(N - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            byte_idx <= byte_idx + BIW'(1);
            state    <= START;
            tx_q     <= 1'b0;
            sh       <= (byte_idx == BIW'(N - 2)) ? csum : words_q[7:0];
            if (byte_idx != BIW'(N - 2)) begin
              words_q <= words_q >> 8;
              csum    <= csum ^ words_q[7:0];
            end
          end
        end else cnt <= cnt + CW'(1);
        DONE: begin
          state    <= IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          cnt      <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          csum     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: three instances (8b/4clk, 16b/4clk, 8b/7clk) with a line decoder and byte scoreboard per instance.
module tb_result_uart_tx;
  typedef struct {int g; logic [7:0] b;} exp_t;
  typedef struct {int g; logic [3:0][31:0] w; int mode; int exp_done;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [2:0] ep = '0;
  logic [3:0][31:0] rw [3];
  logic [2:0] tx_v, busy_v, done_v;
  exp_t exp_q[$];
  vec_t tbl[6];
  result_uart_tx_if #(.DATA_W(8))  if0 ();
  result_uart_tx_if #(.DATA_W(16)) if1 ();
  result_uart_tx_if #(.DATA_W(8))  if2 ();
  assign if0.end_process = ep[0];
  assign if1.end_process = ep[1];
  assign if2.end_process = ep[2];
  assign {if0.r4, if0.r3, if0.r2, if0.r1} = {rw[0][3][7:0], rw[0][2][7:0], rw[0][1][7:0], rw[0][0][7:0]};
  assign {if1.r4, if1.r3, if1.r2, if1.r1} = {rw[1][3][15:0], rw[1][2][15:0], rw[1][1][15:0], rw[1][0][15:0]};
  assign {if2.r4, if2.r3, if2.r2, if2.r1} = {rw[2][3][7:0], rw[2][2][7:0], rw[2][1][7:0], rw[2][0][7:0]};
  assign tx_v   = {if2.tx, if1.tx, if0.tx};
  assign busy_v = {if2.busy, if1.busy, if0.busy};
  assign done_v = {if2.done, if1.done, if0.done};
  result_uart_tx #(.DATA_W(8),  .CLKS_PER_BIT(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  result_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  result_uart_tx #(.DATA_W(8),  .CLKS_PER_BIT(7)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction
  function automatic int dw(int g);
    return (g == 1) ? 16 : 8;
  endfunction
  function automatic void push_exp(int g, logic [3:0][31:0] w);
    logic [7:0] cs, b;
    cs = '0;
    exp_q.push_back('{g, 8'hA5});
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < dw(g) / 8; k++) begin
        b = w[i][8*k +: 8];
        cs ^= b;
        exp_q.push_back('{g, b});
      end
    exp_q.push_back('{g, cs});
  endfunction
  // Line decoder: samples mid-bit, checks framing and bit-run lengths, pops the scoreboard per byte.
  for (genvar g = 0; g < 3; g++) begin : mon
    localparam int P = (g == 2) ? 7 : 4;
    int cnt = 0;
    int rl = 0;
    bit active = 1'b0;
    bit run_on = 1'b0;
    logic prev = 1'b1;
    logic [9:0] sh = '0;
    exp_t e;
    always @(negedge clk) begin
      if (!rst_n) begin
        active = 1'b0;
        run_on = 1'b0;
      end else begin
        if (run_on) begin
          if (tx_v[g] !== prev) begin
            chk("run_len", rl % P, 0);
            rl = 1;
          end else rl++;
          if (busy_v[g] !== 1'b1) run_on = 1'b0;
        end else if (busy_v[g] === 1'b1 && tx_v[g] === 1'b0) begin
          run_on = 1'b1;
          rl = 1;
        end
        prev = tx_v[g];
        if (active) cnt++;
        else if (tx_v[g] === 1'b0) begin
          active = 1'b1;
          cnt = 0;
        end
        if (active && cnt % P == P / 2) begin
          sh[cnt/P] = tx_v[g];
          if (cnt / P == 9) begin
            active = 1'b0;
            chk("start_bit", sh[0], 0);
            chk("stop_bit", sh[9], 1);
            if (exp_q.size() == 0) chk("extra_byte", sh[8:1], 32'hFFFF_FFFF);
            else begin
              e = exp_q.pop_front();
              chk("byte_inst", g, e.g);
              chk("byte_val", sh[8:1], e.b);
            end
          end
        end
      end
    end
  end
  task automatic start_frame(input int g, input logic [3:0][31:0] w, output int c0);
    rw[g] = w;
    push_exp(g, w);
    ep[g] = 1'b1;
    c0 = cyc;
  endtask
  task automatic wait_done(input int g, input int c0, input int exp_rel, input int mode);
    int first, dn, gap, rel;
    first = -1;
    dn = 0;
    gap = 0;
    for (int k = 0; k < exp_rel + 20; k++) begin
      @(negedge clk);
      rel = cyc - c0;
      if (rel == 1) begin
        chk("tx_fall", tx_v[g], 0);
        chk("busy_rise", busy_v[g], 1);
      end
      if (rel == 3 && mode < 2) ep[g] = 1'b0;
      if (mode == 1 && rel == 50) begin
        for (int i = 0; i < 4; i++) rw[g][i] = 32'hEEEE_EEEE;
        ep[g] = 1'b1;
      end
      if (mode == 1 && rel == 60) ep[g] = 1'b0;
      if (done_v[g] === 1'b1) begin
        dn++;
        if (first < 0) begin
          first = rel;
          chk("tx_at_done", tx_v[g], 1);
          chk("busy_at_done", busy_v[g], 1);
          if (mode == 3) ep[g] = 1'b0;
        end
      end else if (first < 0 && busy_v[g] !== 1'b1) gap++;
      if (first >= 0 && rel == first + 1) break;
    end
    chk("done_cycle", first, exp_rel);
    chk("done_pulses", dn, 1);
    chk("busy_gap", gap, 0);
    chk("busy_fall", busy_v[g], 0);
  endtask
  task automatic idle_check(input int g, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy_v[g] !== 1'b0 || tx_v[g] !== 1'b1) bad++;
    end
    chk("stays_idle", bad, 0);
  endtask
  initial begin
    int c0;
    logic [3:0][31:0] w;
    tbl[0] = '{0, {32'h08, 32'h04, 32'h02, 32'h01}, 0, 241};
    tbl[1] = '{1, {32'hFFFF, 32'h0000, 32'hABCD, 32'h1234}, 0, 401};
    tbl[2] = '{2, {32'h00, 32'hFF, 32'hC3, 32'h5A}, 0, 421};
    tbl[3] = '{0, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 241};
    tbl[4] = '{2, {32'hFE, 32'h01, 32'h7F, 32'h80}, 2, 421};
    tbl[5] = '{1, {32'h8001, 32'h0F0F, 32'hBEEF, 32'hDEAD}, 3, 401};
    for (int g = 0; g < 3; g++) rw[g] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_tx", tx_v[g], 1);
      chk("reset_busy", busy_v[g], 0);
      chk("reset_done", done_v[g], 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start_frame(tbl[i].g, tbl[i].w, c0);
      wait_done(tbl[i].g, c0, tbl[i].exp_done, tbl[i].mode);
      if (tbl[i].mode == 3) begin
        w = ~tbl[i].w;
        start_frame(tbl[i].g, w, c0);
        wait_done(tbl[i].g, c0, tbl[i].exp_done, 0);
      end
      if (tbl[i].mode == 1 || tbl[i].mode == 2) idle_check(tbl[i].g, 40);
      ep[tbl[i].g] = 1'b0;
      repeat (5) @(negedge clk);
    end
    w = {32'h66, 32'h99, 32'hC3, 32'h3C};
    @(negedge clk);
    start_frame(0, w, c0);
    while (cyc - c0 < 127) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx_v[0], 1);
    chk("async_rst_busy", busy_v[0], 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    push_exp(0, w);
    rst_n = 1'b1;
    c0 = cyc;
    wait_done(0, c0, 241, 0);
    idle_check(0, 20);
    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
